// File: rtl/niios_qsys_nios2_mult_seq.sv
// Sequential DATA_W x DATA_W multiplier: one SLICE_W slice of src2 per cycle, full 2*DATA_W product.
// Optional build macro NIIOS_MULT_SEQ_EARLY_OUT_EN finishes as soon as the remaining src2 slices are zero.
module niios_qsys_nios2_mult_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              req_sign1,
  input  logic              req_sign2,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [1:0]        dbg_state
);

  localparam int N_SLICE = DATA_W / SLICE_W;
  localparam int P_W     = 2 * DATA_W;
  localparam int K_W     = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds its
  // payload stable until then, and ready never depends combinationally on valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [P_W-1:0]     src1_ext;
  logic [DATA_W-1:0]  src2_q;
  logic               sign2_q;
  logic [P_W-1:0]     acc;
  logic [K_W-1:0]     k;

  logic [SLICE_W-1:0] slice;
  logic [P_W-1:0]     slice_ext;
  logic [P_W-1:0]     partial;
  logic [P_W-1:0]     acc_nxt;
  logic               is_last;
  logic               calc_done;
`ifdef NIIOS_MULT_SEQ_EARLY_OUT_EN
  logic               upper_zero;
`endif

  always_comb begin
    slice   = src2_q[int'(k)*SLICE_W +: SLICE_W];
    is_last = (k == K_W'(N_SLICE - 1));
    // Only the top slice carries src2's sign; lower slices are plain magnitudes.
    if (is_last && sign2_q)
      slice_ext = {{(P_W-SLICE_W){slice[SLICE_W-1]}}, slice};
    else
      slice_ext = {{(P_W-SLICE_W){1'b0}}, slice};
    partial = src1_ext * slice_ext;
    acc_nxt = acc + (partial << (int'(k) * SLICE_W));
`ifdef NIIOS_MULT_SEQ_EARLY_OUT_EN
    upper_zero = ((src2_q >> ((int'(k) + 1) * SLICE_W)) == '0);
    calc_done  = is_last || upper_zero;
`else
    calc_done  = is_last;
`endif
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req_valid) state_nxt = S_CALC;
        S_CALC:  if (calc_done) state_nxt = S_DONE;
        S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_ext <= '0;
      src2_q   <= '0;
      sign2_q  <= 1'b0;
      acc      <= '0;
      k        <= '0;
      rsp_lo   <= '0;
      rsp_hi   <= '0;
    end else if (flush) begin
      acc <= '0;
      k   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            src1_ext <= req_sign1 ? {{DATA_W{req_src1[DATA_W-1]}}, req_src1}
                                  : {{DATA_W{1'b0}}, req_src1};
            src2_q   <= req_src2;
            sign2_q  <= req_sign2;
            acc      <= '0;
            k        <= '0;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          k   <= k + K_W'(1);
          if (calc_done) begin
            rsp_lo <= acc_nxt[DATA_W-1:0];
            rsp_hi <= acc_nxt[P_W-1:DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_DONE);
  assign dbg_state = state;

endmodule
